// File: rtl/parada_rampa.sv
// ---------------------------------------------------------------------------
// parada_rampa -- soft-stop (ramp-down) controller for the motor speed stage.
//
// While the motor runs the drive is held at 100%. A stop request walks the
// drive down 100 -> 50 -> 30 -> off, holding each intermediate level for a
// dwell of D cycles (D chosen by Lento at the moment of the request). Rapido
// cuts the drive straight to off, either at the request or mid-ramp.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous reset, active low
//   en_marcha   in   motor-running indication from the start ramp
//   Parar       in   stop request (level, sampled every cycle)
//   Rapido      in   fast stop / ramp abort
//   Lento       in   slow stop: use DWELL_LENTO instead of DWELL_NORMAL
//   out_100     out  drive at 100%
//   out_50      out  drive at 50%
//   out_30      out  drive at 30%
//   parado      out  motor stopped, no drive level active
//   fin_parada  out  one-cycle pulse on entry to the stopped state
// ---------------------------------------------------------------------------
module parada_rampa #(
  parameter int CNT_W        = 16,
  parameter int DWELL_NORMAL = 4,
  parameter int DWELL_LENTO  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en_marcha,
  input  logic Parar,
  input  logic Rapido,
  input  logic Lento,
  output logic out_100,
  output logic out_50,
  output logic out_30,
  output logic parado,
  output logic fin_parada
);

  localparam longint LP_MAX = (longint'(1) << CNT_W) - longint'(1);

  // Reject dwell values the counter cannot represent (or zero dwell).
  generate
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
      $error("parada_rampa: CNT_W must be in 1..32");
    end
    if (longint'(DWELL_NORMAL) < longint'(1) || longint'(DWELL_NORMAL) > LP_MAX) begin : g_bad_normal
      $error("parada_rampa: DWELL_NORMAL must be in 1..2^CNT_W-1");
    end
    if (longint'(DWELL_LENTO) < longint'(1) || longint'(DWELL_LENTO) > LP_MAX) begin : g_bad_lento
      $error("parada_rampa: DWELL_LENTO must be in 1..2^CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LP_NORMAL = CNT_W'(DWELL_NORMAL);
  localparam logic [CNT_W-1:0] LP_LENTO  = CNT_W'(DWELL_LENTO);
  localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_ZERO   = '0;

  typedef enum logic [1:0] {
    ST_PARADO  = 2'd0,
    ST_MARCHA  = 2'd1,
    ST_BAJA_50 = 2'd2,
    ST_BAJA_30 = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_dwell;
  logic             r_fin;

  state_t           w_state_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_dwell_next;
  logic [CNT_W-1:0] w_dwell_sel;
  logic             w_fin_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_PARADO;
      r_cnt   <= LP_ZERO;
      r_dwell <= LP_NORMAL;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_dwell <= w_dwell_next;
      r_fin   <= w_fin_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_dwell_next = r_dwell;
    w_dwell_sel  = Lento ? LP_LENTO : LP_NORMAL;

    case (r_state)
      ST_PARADO: begin
        // A concurrent stop request blocks the start.
        if (en_marcha && !Parar) begin
          w_state_next = ST_MARCHA;
        end
      end

      ST_MARCHA: begin
        if (Parar) begin
          if (Rapido) begin
            w_state_next = ST_PARADO;
          end else begin
            // Dwell is frozen here so later Lento changes cannot stretch
            // or shorten a ramp already under way.
            w_state_next = ST_BAJA_50;
            w_dwell_next = w_dwell_sel;
            w_cnt_next   = w_dwell_sel - LP_ONE;
          end
        end
      end

      ST_BAJA_50, ST_BAJA_30: begin
        if (Rapido) begin
          w_state_next = ST_PARADO;
        end else if (r_cnt == LP_ZERO) begin
          w_state_next = (r_state == ST_BAJA_50) ? ST_BAJA_30 : ST_PARADO;
          w_cnt_next   = r_dwell - LP_ONE;
        end else begin
          w_cnt_next = r_cnt - LP_ONE;
        end
      end

      default: begin
        w_state_next = ST_PARADO;
      end
    endcase

    // Pulse only on a real transition into PARADO; reset bypasses this path.
    w_fin_next = (w_state_next == ST_PARADO) && (r_state != ST_PARADO);
  end

  assign out_100    = (r_state == ST_MARCHA);
  assign out_50     = (r_state == ST_BAJA_50);
  assign out_30     = (r_state == ST_BAJA_30);
  assign parado     = (r_state == ST_PARADO);
  assign fin_parada = r_fin;

endmodule

// File: tb/tb_parada_rampa.sv
// ---------------------------------------------------------------------------
// tb_parada_rampa -- self-checking bench for parada_rampa.
// Directed vectors with hand-written expectations, a few multi-cycle corner
// sequences, then randomized stimulus compared against a schedule-based
// reference model (a queue of upcoming drive levels).
// ---------------------------------------------------------------------------
module tb_parada_rampa;

  localparam int DN = 4;
  localparam int DL = 8;

  logic clk = 1'b0;
  logic reset, en_marcha, Parar, Rapido, Lento;
  logic out_100, out_50, out_30, parado, fin_parada;

  always #5 clk = ~clk;

  parada_rampa #(.CNT_W(16), .DWELL_NORMAL(DN), .DWELL_LENTO(DL)) dut (
    .clk(clk), .reset(reset), .en_marcha(en_marcha), .Parar(Parar),
    .Rapido(Rapido), .Lento(Lento), .out_100(out_100), .out_50(out_50),
    .out_30(out_30), .parado(parado), .fin_parada(fin_parada)
  );

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  // ---------------- reference model ----------------
  typedef enum int {M_STOP, M_RUN, M_L50, M_L30} lvl_e;
  lvl_e m_cur = M_STOP;
  lvl_e plan[$];
  bit   m_fin = 1'b0;

  task automatic model_edge(input logic r, input logic en, input logic p,
                            input logic rp, input logic ln);
    int d;
    m_fin = 1'b0;
    if (!r) begin
      plan.delete();
      m_cur = M_STOP;
    end else begin
      case (m_cur)
        M_STOP: if (en && !p) m_cur = M_RUN;
        M_RUN: begin
          if (p && rp) begin
            m_cur = M_STOP;
            m_fin = 1'b1;
          end else if (p) begin
            d = ln ? DL : DN;
            m_cur = M_L50;
            for (int i = 1; i < d; i++) plan.push_back(M_L50);
            for (int i = 0; i < d; i++) plan.push_back(M_L30);
          end
        end
        default: begin
          if (rp || plan.size() == 0) begin
            plan.delete();
            m_cur = M_STOP;
            m_fin = 1'b1;
          end else begin
            m_cur = plan.pop_front();
          end
        end
      endcase
    end
  endtask

  function automatic logic [4:0] model_out();
    return {m_cur == M_RUN, m_cur == M_L50, m_cur == M_L30, m_cur == M_STOP, m_fin};
  endfunction

  function automatic logic [4:0] obs();
    return {out_100, out_50, out_30, parado, fin_parada};
  endfunction

  task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b expected=%b (o100 o50 o30 parado fin)",
               name, cycle, got, exp);
    end
  endtask

  // Apply one cycle of inputs, clock, then check against the model and the
  // level one-hot/zero invariant.
  task automatic step(input logic r, input logic en, input logic p,
                      input logic rp, input logic ln);
    int lv;
    reset = r; en_marcha = en; Parar = p; Rapido = rp; Lento = ln;
    @(posedge clk);
    model_edge(r, en, p, rp, ln);
    #1;
    cycle++;
    chk("model", obs(), model_out());
    lv = int'(out_100) + int'(out_50) + int'(out_30);
    checks++;
    if (lv > 1) begin
      failures++;
      $display("FAIL onehot cycle=%0d active_levels=%0d expected<=1", cycle, lv);
    end
  endtask

  // Starting in MARCHA: issue a stop, toggle Lento on the 3rd ramp cycle if
  // asked, and count cycles of out_50 / out_30 until parado.
  task automatic ramp_count(input logic ln, input bit toggle, output int n50,
                            output int n30, output bit done);
    int k;
    n50 = 0; n30 = 0; done = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0, ln);
    for (k = 0; k < 40 && !done; k++) begin
      if (out_50) n50++;
      if (out_30) n30++;
      if (parado) done = 1'b1;
      else step(1'b1, 1'b0, 1'b0, 1'b0, (toggle && k >= 2) ? ~ln : ln);
    end
  endtask

  typedef struct {
    logic       rst, en, par, rap, len;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[18];

  initial begin
    int n50, n30;
    bit done;

    // {reset, en_marcha, Parar, Rapido, Lento, {o100,o50,o30,parado,fin}}
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00010}; // reset
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00010};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10000}; // start
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b10000}; // en drop ignored
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b01000}; // stop request
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01000};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01000};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b01000};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00100};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00100};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00100};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00100};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00011}; // stopped + pulse
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00010};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00010}; // stop beats start
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b10000};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b00011}; // Rapido wins
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00010};

    reset = 1'b0; en_marcha = 1'b1; Parar = 1'b1; Rapido = 1'b0; Lento = 1'b0;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].par, vecs[i].rap, vecs[i].len);
      chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
      $display("vec %0d: in=%b%b%b%b%b out=%b", i, vecs[i].rst, vecs[i].en,
               vecs[i].par, vecs[i].rap, vecs[i].len, obs());
    end

    // Slow stop: 8/8.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ramp_count(1'b1, 1'b0, n50, n30, done);
    chk("slow_done", {4'b0, done}, 5'd1);
    chk("slow_n50", 5'(n50), 5'(DL));
    chk("slow_n30", 5'(n30), 5'(DL));
    $display("slow stop: n50=%0d n30=%0d", n50, n30);

    // Slow stop with Lento dropped mid-ramp: still 8/8.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    ramp_count(1'b1, 1'b1, n50, n30, done);
    chk("latch_done", {4'b0, done}, 5'd1);
    chk("latch_n50", 5'(n50), 5'(DL));
    chk("latch_n30", 5'(n30), 5'(DL));
    $display("latched slow stop: n50=%0d n30=%0d", n50, n30);

    // Rapido on the 2nd cycle of out_30.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < DN; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_30_first", obs(), 5'b00100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_30_second", obs(), 5'b00100);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("abort_stop", obs(), 5'b00011);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_after", obs(), 5'b00010);
    $display("abort in out_30: out=%b", obs());

    // Reset during BAJA_50: stopped, no pulse.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_pre", obs(), 5'b01000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid", obs(), 5'b00010);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_after", obs(), 5'b00010);
    $display("reset mid-ramp: out=%b", obs());

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      logic r, en, p, rp, ln;
      r  = ($urandom_range(0, 59) != 0);
      en = $urandom_range(0, 1) == 1;
      p  = ($urandom_range(0, 5) == 0);
      rp = ($urandom_range(0, 9) == 0);
      ln = $urandom_range(0, 1) == 1;
      step(r, en, p, rp, ln);
    end
    $display("random phase: %0d cycles", 3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parada_rampa.md
Name: parada_rampa

Overview:
- Soft-stop (ramp-down) controller for the motor speed stage; the opposite direction of the soft-start ramp.
- Holds the motor at 100% while running. On a stop request it steps the drive down 100 -> 50 -> 30 -> off, with a programmable dwell at each step.
- A fast-stop input cuts the drive immediately.
- Outputs are the same one-hot speed levels (out_100/out_50/out_30) that the speed stage already consumes.

Parameters:
- CNT_W, 16, width of the dwell counter.
- DWELL_NORMAL, 4, cycles held at each intermediate level (50%, 30%) for a normal stop; legal range 1..2^CNT_W-1.
- DWELL_LENTO, 8, cycles held at each intermediate level when Lento is sampled at the stop request; legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the block).
- en_marcha  input  1  motor-running indication from the start ramp (its 100% level); level-sensitive.
- Parar  input  1  stop request; level-sensitive, sampled each cycle.
- Rapido  input  1  fast stop: go straight to off.
- Lento  input  1  slow stop: use DWELL_LENTO instead of DWELL_NORMAL.
- out_100  output  1  drive at 100%.
- out_50  output  1  drive at 50%.
- out_30  output  1  drive at 30%.
- parado  output  1  motor stopped (no drive level active).
- fin_parada  output  1  single-cycle pulse on entry to PARADO from any other state.

Behaviour:
- Registered Moore FSM. Outputs decode from the state register only, so they change one cycle after the inputs are sampled. out_100/out_50/out_30 are one-hot or all-zero, never two at once.
- States and outputs:
  - PARADO: parado=1, all levels 0.
  - MARCHA: out_100=1.
  - BAJA_50: out_50=1.
  - BAJA_30: out_30=1.
- Reset (reset==0 at an edge): state=PARADO, counter=0, dwell latch=DWELL_NORMAL, fin_parada=0. Outputs after the edge are parado=1, all levels 0. Reset overrides everything, including mid-ramp.
- PARADO:
  - en_marcha=1 and Parar=0 -> MARCHA.
  - Parar=1 -> stay in PARADO (stop has priority over start).
- MARCHA:
  - Parar=1 and Rapido=1 -> PARADO.
  - Parar=1 and Rapido=0 -> BAJA_50. Latch dwell D = Lento ? DWELL_LENTO : DWELL_NORMAL and load counter = D-1.
  - Parar=0 -> stay in MARCHA. en_marcha dropping without Parar is ignored.
- BAJA_50:
  - Rapido=1 -> PARADO (abort).
  - Else if counter==0 -> BAJA_30, counter reloaded to D-1.
  - Else counter decrements.
  - out_50 is therefore high for exactly D cycles.
- BAJA_30: same rules as BAJA_50; at counter==0 -> PARADO. out_30 is high for exactly D cycles.
- Inputs ignored during BAJA_50/BAJA_30: Lento changes (D is latched), en_marcha, and Parar deasserting. A started ramp always completes or aborts; it never returns to MARCHA.
- Rapido and Lento both 1 at the stop request: Rapido wins (immediate stop).
- fin_parada is registered: 1 for the first cycle the state is PARADO after MARCHA, BAJA_50 or BAJA_30, else 0. It does not pulse after reset.
- Counter arithmetic: unsigned CNT_W bits, decrement only while nonzero, no wrap-around. Parameters of 0 or of values that do not fit CNT_W are illegal; add an elaboration check.

Test Plan:
- Reset: hold reset=0 for 2 cycles with en_marcha=1, Parar=1 -> parado=1, out_100/out_50/out_30=0, fin_parada=0 throughout.
- Normal stop: en_marcha=1 -> out_100=1 next cycle. Then a 1-cycle Parar with Lento=0 -> out_50=1 for exactly 4 cycles, out_30=1 for 4 cycles, then parado=1 with fin_parada=1 for exactly 1 cycle.
- Slow stop and latch: Parar with Lento=1 -> out_50 for 8 cycles and out_30 for 8 cycles. Toggle Lento=0 during BAJA_50 -> durations are still 8/8.
- Fast stop and abort:
  - Parar with Rapido=1 in MARCHA -> parado=1 the next cycle; out_50/out_30 never asserted.
  - Rapido=1 on the 2nd cycle of out_30 -> parado=1 the next cycle, fin_parada pulses once.
- Priority and reset mid-ramp:
  - Parar=1 and en_marcha=1 together in PARADO -> stays parado=1.
  - reset=0 during BAJA_50 -> parado=1 after that edge, no fin_parada pulse.
  - Check the one-hot/zero invariant of the level outputs on every cycle.
